mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one pipelined multiplier (default: radix4BoothWithRegs, MUL_LATENCY=2) among NUM_REQ requesters.
- Round-robin issue of at most one operation per cycle; each in-flight operation is tagged with its requester ID.
- Every result returns on a shared response bus with ID, product and overflow.
- Sits between datapath clients and the multiplier; owns the multiplier's operand and enable inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand width in bits
- MUL_LATENCY, 2, clock edges from mul_a/mul_b update to valid mul_result/mul_overflow
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH], two's complement
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- req_ready  out  NUM_REQ  one-hot grant; accept = req_valid[i] & req_ready[i]
- mul_a  out  WIDTH  registered operand A to the multiplier
- mul_b  out  WIDTH  registered operand B to the multiplier
- mul_en  out  1  multiplier register enable
- mul_result  in  2*WIDTH  signed product from the multiplier
- mul_overflow  in  1  overflow flag from the multiplier
- rsp_valid  out  1  response valid, one cycle per operation
- rsp_id  out  ID_W  requester index of the response
- rsp_result  out  2*WIDTH  signed product
- rsp_overflow  out  1  overflow flag for this product
- ops_count  out  32  number of responses delivered since reset, wraps

Behaviour:
- Reset (synchronous):
  - mul_a, mul_b, rsp_result, rsp_id, ops_count = 0.
  - mul_en, rsp_valid, rsp_overflow = 0.
  - Round-robin pointer = 0; tag pipeline cleared.
- mul_en is 1 from the first edge after reset deasserts and stays 1; the multiplier runs every cycle.
- Grant logic (combinational from req_valid and pointer):
  - Search from the pointer upward, modulo NUM_REQ; the first asserted req_valid gets req_ready.
  - req_ready is all-zero when no requester is valid or reset=1.
  - At most one bit set; the requester need not wait for ready before asserting valid.
- On an accept edge:
  - mul_a/mul_b <= the granted operands.
  - pointer <= granted+1, mod NUM_REQ; the pointer does not move on idle cycles.
  - Tag pipeline stage 0 <= {valid=1, id=granted}. A non-accept cycle shifts in valid=0.
- Tag pipeline: MUL_LATENCY+1 stages; it shifts every cycle and never stalls (no response backpressure).
- Response, registered:
  - When the tag for an operation reaches the stage aligned with valid mul_result, the next edge loads rsp_valid=1, rsp_id=tag id, rsp_result=mul_result, rsp_overflow=mul_overflow.
  - Otherwise rsp_valid=0, and the other rsp fields hold their last value.
- Latency:
  - Accept edge E → rsp_valid high in the cycle following edge E+MUL_LATENCY+1.
  - Default: 3 cycles after the accept cycle.
- Throughput: one accept per cycle sustained; responses return in accept order, back-to-back.
- ops_count increments on each edge that loads rsp_valid=1; it wraps from 2^32-1 to 0.
- Same requester continuously valid while others are idle: it is granted every cycle.
- Reset mid-operation:
  - All in-flight tags are discarded; no responses are produced for them.
  - The pointer returns to 0.
  - mul_result values arriving after reset are ignored.
- Arithmetic: the block does not modify operands or products; signedness is the multiplier's. rsp_overflow passes through unchanged.

Test Plan:
- Single op: after reset, requester 1 presents a=5, b=-7 for one cycle → req_ready=0010 that cycle; 3 cycles later rsp_valid=1, rsp_id=1, rsp_result=-35, rsp_overflow=0; ops_count=1.
- All four requesters valid, each for one accept, with operands (2,3), (-12,-4), (-9,5), (11,0) → grants in order 0,1,2,3 on consecutive cycles; responses back-to-back with ids 0,1,2,3 and results 6, 48, -45, 0.
- Fairness: after a grant to requester 2, requesters 0 and 3 both valid → requester 3 granted first, then 0.
- Streaming: requester 0 holds valid for 4 cycles with (10,1), (4,6), (-1,-7), (-1,-1) → 4 accepts on consecutive cycles; results 10, 24, 7, 1 on 4 consecutive rsp_valid cycles.
- Reset mid-flight: accept two ops, then pulse reset on the next cycle → no rsp_valid afterwards; ops_count=0; the next request granted is requester 0 if valid.
- Idle and edge cases:
  - No req_valid for 10 cycles → req_ready=0, rsp_valid=0, pointer unchanged.
  - a=-2147483648, b=-2147483648 → rsp_result=4611686018427387904.

Source files
------------

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arbiter
// Purpose  : Round-robin sharing of one pipelined multiplier among NUM_REQ
//            requesters; every product returns tagged with its requester ID.
// Revision : 1.0  initial release
// ============================================================================
module mul_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2,
    parameter int ID_W        = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_en,
    input  logic [2*WIDTH-1:0]       mul_result,
    input  logic                     mul_overflow,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     rsp_overflow,
    output logic [31:0]              ops_count
);

    localparam int              c_tag_last = MUL_LATENCY;
    localparam logic [ID_W-1:0] c_last_id  = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]    r_ptr;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic               r_mul_en;
    logic               r_tag_v  [0:c_tag_last];
    logic [ID_W-1:0]    r_tag_id [0:c_tag_last];
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [2*WIDTH-1:0] r_rsp_result;
    logic               r_rsp_overflow;
    logic [31:0]        r_ops_count;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_found;
    logic               w_accept;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [ID_W-1:0]    w_ptr_next;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        int w_idx;
        w_grant  = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_gnt_id       = ID_W'(w_idx);
                w_sel_a        = req_a[w_idx*WIDTH +: WIDTH];
                w_sel_b        = req_b[w_idx*WIDTH +: WIDTH];
            end
        end
    end

    assign w_accept   = w_found & ~reset;
    assign req_ready  = reset ? '0 : w_grant;
    assign w_ptr_next = (w_gnt_id == c_last_id) ? '0 : w_gnt_id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr    <= '0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_mul_en <= 1'b0;
        end else begin
            r_mul_en <= 1'b1;
            if (w_accept) begin
                r_ptr   <= w_ptr_next;
                r_mul_a <= w_sel_a;
                r_mul_b <= w_sel_b;
            end
        end
    end

    // Tags travel alongside the multiplier pipeline; the last stage lines up
    // with the cycle in which mul_result holds that operation's product.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s <= c_tag_last; s++) begin
                r_tag_v[s]  <= 1'b0;
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_accept;
            r_tag_id[0] <= w_gnt_id;
            for (int s = 1; s <= c_tag_last; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= '0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_ops_count    <= '0;
        end else begin
            r_rsp_valid <= r_tag_v[c_tag_last];
            if (r_tag_v[c_tag_last]) begin
                r_rsp_id       <= r_tag_id[c_tag_last];
                r_rsp_result   <= mul_result;
                r_rsp_overflow <= mul_overflow;
                r_ops_count    <= r_ops_count + 32'd1;
            end
        end
    end

    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign mul_en       = r_mul_en;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_overflow;
    assign ops_count    = r_ops_count;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_share_arbiter
// Purpose  : Scenario and randomized checks of mul_share_arbiter against a
//            queue-based reference model and a behavioural 2-stage multiplier.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int L  = 2;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic             mul_en;
    logic [2*W-1:0]   mul_result;
    logic             mul_overflow;
    logic             rsp_valid;
    logic [IW-1:0]    rsp_id;
    logic [2*W-1:0]   rsp_result;
    logic             rsp_overflow;
    logic [31:0]      ops_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul_share_arbiter #(
        .NUM_REQ(N), .WIDTH(W), .MUL_LATENCY(L), .ID_W(IW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
        .mul_result(mul_result), .mul_overflow(mul_overflow),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .ops_count(ops_count)
    );

    // Behavioural multiplier: product visible two edges after operands change.
    // Overflow is an arbitrary product-derived bit so pass-through is observable.
    logic signed [W-1:0]   fm_a;
    logic signed [W-1:0]   fm_b;
    logic signed [2*W-1:0] fm_p;
    logic [2*W-1:0]        fm_s1;
    logic                  fm_o1;
    assign fm_a = mul_a;
    assign fm_b = mul_b;
    assign fm_p = fm_a * fm_b;
    always @(posedge clk) begin
        if (mul_en) begin
            fm_s1        <= fm_p;
            fm_o1        <= fm_p[2*W-1] ^ fm_p[0];
            mul_result   <= fm_s1;
            mul_overflow <= fm_o1;
        end
    end

    // Reference model: pointer, FIFO of outstanding products with due edge.
    typedef struct {
        int             due;
        int             id;
        logic [2*W-1:0] p;
        logic           o;
    } pend_t;

    pend_t          m_q[$];
    int             m_ptr  = 0;
    int             m_edge = 0;
    logic           m_rv   = 1'b0;
    logic [IW-1:0]  m_id   = '0;
    logic [2*W-1:0] m_res  = '0;
    logic           m_ovf  = 1'b0;
    logic [31:0]    m_cnt  = '0;
    logic [N-1:0]   obs_ready;
    logic [N-1:0]   exp_ready;

    function automatic int model_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N*W-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
        return {x3, x2, x1, x0};
    endfunction

    function automatic int rand_operand();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return -1;
            2: return 32'sh8000_0000;
            3: return 32'sh7fff_ffff;
            default: return int'($urandom);
        endcase
    endfunction

    // One clock: drive at the falling edge, sample ready before the rising
    // edge, advance the model at the rising edge, return at the next fall.
    task automatic step(input logic rst, input logic [N-1:0] v,
                        input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        int                    g;
        logic signed [W-1:0]   sa;
        logic signed [W-1:0]   sb;
        logic signed [2*W-1:0] p;
        pend_t                 e;
        reset = rst; req_valid = v; req_a = a; req_b = b;
        #1;
        obs_ready = req_ready;
        g = rst ? -1 : model_pick(v);
        exp_ready = (g < 0) ? '0 : (N'(1) << g);
        @(posedge clk);
        m_edge++;
        if (rst) begin
            m_q.delete();
            m_ptr = 0; m_rv = 1'b0; m_id = '0; m_res = '0; m_ovf = 1'b0; m_cnt = '0;
        end else begin
            if (g >= 0) begin
                sa = a[g*W +: W];
                sb = b[g*W +: W];
                p  = sa * sb;
                e.due = m_edge + L + 1; e.id = g; e.p = p; e.o = p[2*W-1] ^ p[0];
                m_q.push_back(e);
                m_ptr = (g + 1) % N;
            end
            m_rv = 1'b0;
            if (m_q.size() > 0 && m_q[0].due == m_edge) begin
                e = m_q.pop_front();
                m_rv = 1'b1; m_id = IW'(e.id); m_res = e.p; m_ovf = e.o;
                m_cnt = m_cnt + 32'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            step(c < 3, '1, pack4(3, 4, 5, 6), pack4(7, 8, 9, 10));
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_errors++; $display("FAIL reset ready cyc=%0d got=%b want=%b", c, obs_ready, exp_ready);
            end
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, ops_count} !== {m_rv, m_id, m_res, m_ovf, m_cnt}) begin
                n_errors++; $display("FAIL reset rsp cyc=%0d got v=%b id=%0d cnt=%0d want v=%b id=%0d cnt=%0d",
                                     c, rsp_valid, rsp_id, ops_count, m_rv, m_id, m_cnt);
            end
            if (c < 3) begin
                n_checks++;
                if ({mul_en, mul_a, mul_b} !== '0) begin
                    n_errors++; $display("FAIL reset mul_if got en=%b a=%0h b=%0h want 0", mul_en, mul_a, mul_b);
                end
            end else begin
                n_checks++;
                if (mul_en !== 1'b1) begin
                    n_errors++; $display("FAIL reset mul_en_rise got=%b want=1", mul_en);
                end
            end
        end
    endtask

    task automatic test_single_op();
        for (int c = 0; c < 6; c++) begin
            step(c == 0, (c == 1) ? 4'b0010 : 4'b0000, pack4(0, 5, 0, 0), pack4(0, -7, 0, 0));
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_errors++; $display("FAIL single_op ready cyc=%0d got=%b want=%b", c, obs_ready, exp_ready);
            end
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, ops_count} !== {m_rv, m_id, m_res, m_ovf, m_cnt}) begin
                n_errors++; $display("FAIL single_op rsp cyc=%0d got v=%b id=%0d res=%0d ovf=%b cnt=%0d want v=%b id=%0d res=%0d ovf=%b cnt=%0d",
                                     c, rsp_valid, rsp_id, $signed(rsp_result), rsp_overflow, ops_count,
                                     m_rv, m_id, $signed(m_res), m_ovf, m_cnt);
            end
            if (c == 1) begin
                n_checks++;
                if (obs_ready !== 4'b0010) begin
                    n_errors++; $display("FAIL single_op grant got=%b want=0010", obs_ready);
                end
            end
            if (c == 4) begin
                n_checks++;
                if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, ops_count} !== {1'b1, 2'd1, -64'sd35, 1'b0, 32'd1}) begin
                    n_errors++; $display("FAIL single_op value got v=%b id=%0d res=%0d ovf=%b cnt=%0d want v=1 id=1 res=-35 ovf=0 cnt=1",
                                         rsp_valid, rsp_id, $signed(rsp_result), rsp_overflow, ops_count);
                end
            end
        end
    endtask

    task automatic test_all_four();
        logic [N-1:0]          v;
        logic signed [2*W-1:0] e;
        int                    exp_tab[4] = '{6, 48, -45, 0};
        for (int c = 0; c < 9; c++) begin
            case (c)
                1: v = 4'b1111;
                2: v = 4'b1110;
                3: v = 4'b1100;
                4: v = 4'b1000;
                default: v = 4'b0000;
            endcase
            step(c == 0, v, pack4(2, -12, -9, 11), pack4(3, -4, 5, 0));
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_errors++; $display("FAIL all_four ready cyc=%0d got=%b want=%b", c, obs_ready, exp_ready);
            end
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, ops_count} !== {m_rv, m_id, m_res, m_ovf, m_cnt}) begin
                n_errors++; $display("FAIL all_four rsp cyc=%0d got v=%b id=%0d res=%0d cnt=%0d want v=%b id=%0d res=%0d cnt=%0d",
                                     c, rsp_valid, rsp_id, $signed(rsp_result), ops_count, m_rv, m_id, $signed(m_res), m_cnt);
            end
            if (c >= 1 && c <= 4) begin
                n_checks++;
                if (obs_ready !== (N'(1) << (c - 1))) begin
                    n_errors++; $display("FAIL all_four order cyc=%0d got=%b want=%b", c, obs_ready, N'(1) << (c - 1));
                end
            end
            if (c >= 4 && c <= 7) begin
                e = exp_tab[c-4];
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== IW'(c - 4) || rsp_result !== e) begin
                    n_errors++; $display("FAIL all_four value cyc=%0d got v=%b id=%0d res=%0d want v=1 id=%0d res=%0d",
                                         c, rsp_valid, rsp_id, $signed(rsp_result), c - 4, e);
                end
            end
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] v;
        logic [N-1:0] want;
        for (int c = 0; c < 8; c++) begin
            case (c)
                1: v = 4'b0100;
                2, 3: v = 4'b1001;
                default: v = 4'b0000;
            endcase
            step(c == 0, v, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_errors++; $display("FAIL fairness ready cyc=%0d got=%b want=%b", c, obs_ready, exp_ready);
            end
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, ops_count} !== {m_rv, m_id, m_res, m_ovf, m_cnt}) begin
                n_errors++; $display("FAIL fairness rsp cyc=%0d got v=%b id=%0d res=%0d want v=%b id=%0d res=%0d",
                                     c, rsp_valid, rsp_id, $signed(rsp_result), m_rv, m_id, $signed(m_res));
            end
            if (c >= 1 && c <= 3) begin
                want = (c == 1) ? 4'b0100 : (c == 2) ? 4'b1000 : 4'b0001;
                n_checks++;
                if (obs_ready !== want) begin
                    n_errors++; $display("FAIL fairness order cyc=%0d got=%b want=%b", c, obs_ready, want);
                end
            end
        end
    endtask

    task automatic test_streaming();
        int                    ta[4] = '{10, 4, -1, -1};
        int                    tb[4] = '{1, 6, -7, -1};
        int                    tr[4] = '{10, 24, 7, 1};
        int                    k;
        logic signed [2*W-1:0] e;
        for (int c = 0; c < 9; c++) begin
            k = (c >= 1 && c <= 4) ? c - 1 : 0;
            step(c == 0, (c >= 1 && c <= 4) ? 4'b0001 : 4'b0000, pack4(ta[k], 0, 0, 0), pack4(tb[k], 0, 0, 0));
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_errors++; $display("FAIL streaming ready cyc=%0d got=%b want=%b", c, obs_ready, exp_ready);
            end
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, ops_count} !== {m_rv, m_id, m_res, m_ovf, m_cnt}) begin
                n_errors++; $display("FAIL streaming rsp cyc=%0d got v=%b res=%0d cnt=%0d want v=%b res=%0d cnt=%0d",
                                     c, rsp_valid, $signed(rsp_result), ops_count, m_rv, $signed(m_res), m_cnt);
            end
            if (c >= 4 && c <= 7) begin
                e = tr[c-4];
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== e) begin
                    n_errors++; $display("FAIL streaming value cyc=%0d got v=%b id=%0d res=%0d want v=1 id=0 res=%0d",
                                         c, rsp_valid, rsp_id, $signed(rsp_result), e);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [N-1:0] v;
        for (int c = 0; c < 11; c++) begin
            v = (c == 1) ? 4'b0001 : (c == 2) ? 4'b0010 : (c == 3 || c == 10) ? 4'b1111 : 4'b0000;
            step(c == 0 || c == 3, v, pack4(7, 9, 11, 13), pack4(3, 5, 2, 4));
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_errors++; $display("FAIL midflight ready cyc=%0d got=%b want=%b", c, obs_ready, exp_ready);
            end
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, ops_count} !== {m_rv, m_id, m_res, m_ovf, m_cnt}) begin
                n_errors++; $display("FAIL midflight rsp cyc=%0d got v=%b cnt=%0d want v=%b cnt=%0d",
                                     c, rsp_valid, ops_count, m_rv, m_cnt);
            end
            if (c >= 3 && c <= 9) begin
                n_checks++;
                if (rsp_valid !== 1'b0 || ops_count !== 32'd0) begin
                    n_errors++; $display("FAIL midflight discard cyc=%0d got v=%b cnt=%0d want v=0 cnt=0", c, rsp_valid, ops_count);
                end
            end
            if (c == 10) begin
                n_checks++;
                if (obs_ready !== 4'b0001) begin
                    n_errors++; $display("FAIL midflight ptr got=%b want=0001", obs_ready);
                end
            end
        end
    endtask

    task automatic test_idle();
        logic [N-1:0] v;
        for (int c = 0; c < 17; c++) begin
            v = (c == 1) ? 4'b0010 : (c == 16) ? 4'b1111 : 4'b0000;
            step(c == 0, v, pack4(1, 1, 1, 1), pack4(2, 2, 2, 2));
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_errors++; $display("FAIL idle ready cyc=%0d got=%b want=%b", c, obs_ready, exp_ready);
            end
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, ops_count} !== {m_rv, m_id, m_res, m_ovf, m_cnt}) begin
                n_errors++; $display("FAIL idle rsp cyc=%0d got v=%b cnt=%0d want v=%b cnt=%0d", c, rsp_valid, ops_count, m_rv, m_cnt);
            end
            if (c >= 6 && c <= 15) begin
                n_checks++;
                if (obs_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
                    n_errors++; $display("FAIL idle quiet cyc=%0d got ready=%b v=%b want ready=0000 v=0", c, obs_ready, rsp_valid);
                end
            end
            if (c == 16) begin
                n_checks++;
                if (obs_ready !== 4'b0100) begin
                    n_errors++; $display("FAIL idle ptr_hold got=%b want=0100", obs_ready);
                end
            end
        end
    endtask

    task automatic test_min_operands();
        for (int c = 0; c < 6; c++) begin
            step(c == 0, (c == 1) ? 4'b0100 : 4'b0000,
                 pack4(0, 0, 32'sh8000_0000, 0), pack4(0, 0, 32'sh8000_0000, 0));
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_errors++; $display("FAIL min_operands ready cyc=%0d got=%b want=%b", c, obs_ready, exp_ready);
            end
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, ops_count} !== {m_rv, m_id, m_res, m_ovf, m_cnt}) begin
                n_errors++; $display("FAIL min_operands rsp cyc=%0d got v=%b res=%0h want v=%b res=%0h", c, rsp_valid, rsp_result, m_rv, m_res);
            end
            if (c == 4) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 64'h4000_0000_0000_0000) begin
                    n_errors++; $display("FAIL min_operands value got v=%b id=%0d res=%0h want v=1 id=2 res=4000000000000000",
                                         rsp_valid, rsp_id, rsp_result);
                end
            end
        end
    endtask

    task automatic test_random();
        logic         rst;
        logic [N-1:0] v;
        for (int c = 0; c < 400; c++) begin
            rst = (c == 0) || ($urandom_range(0, 39) == 0);
            v   = N'($urandom);
            step(rst, v,
                 pack4(rand_operand(), rand_operand(), rand_operand(), rand_operand()),
                 pack4(rand_operand(), rand_operand(), rand_operand(), rand_operand()));
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_errors++; $display("FAIL random ready cyc=%0d got=%b want=%b", c, obs_ready, exp_ready);
            end
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, ops_count} !== {m_rv, m_id, m_res, m_ovf, m_cnt}) begin
                n_errors++; $display("FAIL random rsp cyc=%0d got v=%b id=%0d res=%0h ovf=%b cnt=%0d want v=%b id=%0d res=%0h ovf=%b cnt=%0d",
                                     c, rsp_valid, rsp_id, rsp_result, rsp_overflow, ops_count,
                                     m_rv, m_id, m_res, m_ovf, m_cnt);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        test_reset();
        test_single_op();
        test_all_four();
        test_fairness();
        test_streaming();
        test_reset_midflight();
        test_idle();
        test_min_operands();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
